// File: rtl/wb_stage.sv
// Write-back stage: retires MEM instructions into the ID register bank, with multi-cycle load wait/timeout.
// Optional WB_FWD_EN adds forwarding-hit and load-hazard outputs toward ID.
module wb_stage #(
    parameter int unsigned LOAD_TIMEOUT     = 16,
    parameter int unsigned ZERO_REG_PROTECT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_rd,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic        in_link,
    input  logic [15:0] in_alu_result,
    input  logic [15:0] in_pc4,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        RegWrite,
    output logic [2:0]  writeReg,
    output logic [15:0] writeDat,
    output logic        load_err,
    output logic [15:0] retired
`ifdef WB_FWD_EN
    ,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    output logic        fwd_rs_hit,
    output logic        fwd_rt_hit,
    output logic [15:0] fwd_data,
    output logic        hazard_stall
`endif
);

    localparam int unsigned CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      ld_rd;
    logic            ld_we;

    function automatic logic write_enable(input logic we, input logic [2:0] rd);
        return we & ~((ZERO_REG_PROTECT != 0) & (rd == 3'd0));
    endfunction

    assign in_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ld_rd    <= '0;
            ld_we    <= 1'b0;
            RegWrite <= 1'b0;
            writeReg <= '0;
            writeDat <= '0;
            load_err <= 1'b0;
            retired  <= '0;
        end else begin
            RegWrite <= 1'b0;
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Stray load data is dropped; a same-cycle accept still proceeds.
                    if (mem_rvalid)
                        load_err <= 1'b1;
                    if (in_valid) begin
                        if (in_mem_to_reg) begin
                            ld_rd <= in_rd;
                            ld_we <= in_reg_write;
                            cnt   <= '0;
                            state <= WAIT_LOAD;
                        end else begin
                            RegWrite <= write_enable(in_reg_write, in_rd);
                            writeReg <= in_rd;
                            writeDat <= in_link ? in_pc4 : in_alu_result;
                            retired  <= retired + 16'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_rvalid) begin
                        RegWrite <= write_enable(ld_we, ld_rd);
                        writeReg <= ld_rd;
                        writeDat <= mem_rdata;
                        retired  <= retired + 16'd1;
                        state    <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    logic ld_hazard_rd;

    assign fwd_rs_hit   = RegWrite & (writeReg == id_rs);
    assign fwd_rt_hit   = RegWrite & (writeReg == id_rt);
    assign fwd_data     = writeDat;
    assign ld_hazard_rd = write_enable(ld_we, ld_rd);
    assign hazard_stall = (state == WAIT_LOAD) & ld_hazard_rd &
                          ((ld_rd == id_rs) | (ld_rd == id_rt));
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: write expectations are queued at stimulus time and popped by a write monitor.
module tb_wb_stage;

    localparam int unsigned TMO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic        in_link;
    logic [15:0] in_alu_result;
    logic [15:0] in_pc4;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        RegWrite;
    logic [2:0]  writeReg;
    logic [15:0] writeDat;
    logic        load_err;
    logic [15:0] retired;
`ifdef WB_FWD_EN
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        fwd_rs_hit;
    logic        fwd_rt_hit;
    logic [15:0] fwd_data;
    logic        hazard_stall;
`endif

    wb_stage #(
        .LOAD_TIMEOUT(TMO),
        .ZERO_REG_PROTECT(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rd(in_rd),
        .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg),
        .in_link(in_link),
        .in_alu_result(in_alu_result),
        .in_pc4(in_pc4),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .RegWrite(RegWrite),
        .writeReg(writeReg),
        .writeDat(writeDat),
        .load_err(load_err),
        .retired(retired)
`ifdef WB_FWD_EN
        ,
        .id_rs(id_rs),
        .id_rt(id_rt),
        .fwd_rs_hit(fwd_rs_hit),
        .fwd_rt_hit(fwd_rt_hit),
        .fwd_data(fwd_data),
        .hazard_stall(hazard_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] dat;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [15:0] retired_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One instruction presented in IDLE transfers on the next edge; outputs are sampled #1 later.
    task automatic drive_op(input logic [2:0] rd, input logic we, input logic m2r, input logic link,
                            input logic [15:0] alu, input logic [15:0] pc4);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_reg_write  = we;
        in_mem_to_reg = m2r;
        in_link       = link;
        in_alu_result = alu;
        in_pc4        = pc4;
        if (!m2r) begin
            retired_exp = retired_exp + 16'd1;
            if (we && rd != 3'd0)
                exp_q.push_back('{rd: rd, dat: (link ? pc4 : alu)});
        end
        tick();
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", {13'd0, writeReg, writeDat}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_write", {13'd0, writeReg, writeDat}, {13'd0, e.rd, e.dat});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_err;
        logic saw_ready;
        reset = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_link = 1'b0;
        in_alu_result = '0; in_pc4 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
`ifdef WB_FWD_EN
        id_rs = 3'd1; id_rt = 3'd1;
`endif
        retired_exp = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state, then a plain ALU write
        check("rst_regwrite", RegWrite, 0);
        check("rst_writereg", writeReg, 0);
        check("rst_writedat", writeDat, 0);
        check("rst_load_err", load_err, 0);
        check("rst_retired", retired, 0);
        check("rst_in_ready", in_ready, 1);
        drive_op(3'd3, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
        check("alu_regwrite", RegWrite, 1);
        check("alu_writereg", writeReg, 3);
        check("alu_writedat", writeDat, 16'h1234);
        check("alu_retired", retired, retired_exp);

        // 2: link result followed back-to-back by an ALU result
        drive_op(3'd7, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0042);
        check("link_writedat", writeDat, 16'h0042);
        check("link_in_ready", in_ready, 1);
        drive_op(3'd2, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000);
        check("b2b_regwrite", RegWrite, 1);
        check("b2b_writedat", writeDat, 16'h0005);
        check("b2b_retired", retired, retired_exp);

        // 3: load with data three cycles after accept
        drive_op(3'd4, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
        check("ld_in_ready_wait", in_ready, 0);
        check("ld_no_accept_write", RegWrite, 0);
        tick();
        check("ld_in_ready_wait2", in_ready, 0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hBEEF;
        retired_exp = retired_exp + 16'd1;
        exp_q.push_back('{rd: 3'd4, dat: 16'hBEEF});
        tick();
        mem_rvalid = 1'b0;
        check("ld_regwrite", RegWrite, 1);
        check("ld_writereg", writeReg, 4);
        check("ld_writedat", writeDat, 16'hBEEF);
        check("ld_in_ready_done", in_ready, 1);
        check("ld_retired", retired, retired_exp);

        // 4: load timeout after TMO waiting cycles
        drive_op(3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        saw_err = 1'b0;
        saw_ready = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            saw_err   = saw_err | load_err;
            saw_ready = saw_ready | in_ready;
            tick();
        end
        saw_err   = saw_err | load_err;
        saw_ready = saw_ready | in_ready;
        check("tmo_no_early_err", saw_err, 0);
        check("tmo_waiting", saw_ready, 0);
        tick();
        check("tmo_load_err", load_err, 1);
        check("tmo_in_ready", in_ready, 1);
        check("tmo_no_write", RegWrite, 0);
        check("tmo_retired", retired, retired_exp);
        tick();
        check("tmo_err_pulse", load_err, 0);

        // Stray rvalid in IDLE alongside an accepted ALU op
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        drive_op(3'd5, 1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000);
        mem_rvalid = 1'b0;
        check("stray_load_err", load_err, 1);
        check("stray_alu_writedat", writeDat, 16'h0777);
        check("stray_retired", retired, retired_exp);

        // 5: r0 write suppressed but retired
        drive_op(3'd0, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000);
        check("r0_regwrite", RegWrite, 0);
        check("r0_retired", retired, retired_exp);

        // Reset during WAIT_LOAD abandons the load
        drive_op(3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        retired_exp = '0;
        exp_q.delete();
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_writereg", writeReg, 0);
        check("midrst_writedat", writeDat, 0);
        check("midrst_retired", retired, 0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1111;
        tick();
        mem_rvalid = 1'b0;
        check("midrst_abandoned", RegWrite, 0);
        check("midrst_stray_err", load_err, 1);

`ifdef WB_FWD_EN
        // 6: forwarding hit and load hazard
        id_rs = 3'd5; id_rt = 3'd1;
        drive_op(3'd5, 1'b1, 1'b0, 1'b0, 16'h5A5A, 16'h0000);
        check("fwd_rs_hit", fwd_rs_hit, 1);
        check("fwd_rt_miss", fwd_rt_hit, 0);
        check("fwd_data", fwd_data, 16'h5A5A);
        id_rs = 3'd0; id_rt = 3'd5;
        drive_op(3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("hz_stall", hazard_stall, 1);
        tick();
        check("hz_stall_hold", hazard_stall, 1);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hC0DE;
        retired_exp = retired_exp + 16'd1;
        exp_q.push_back('{rd: 3'd5, dat: 16'hC0DE});
        tick();
        mem_rvalid = 1'b0;
        check("hz_released", hazard_stall, 0);
        check("hz_fwd_rt_hit", fwd_rt_hit, 1);
        check("hz_fwd_data", fwd_data, 16'hC0DE);
`endif

        tick();
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
